// File: rtl/ram_access_ctrl_pkg.sv
// Shared types and default sizes for the RAM access controller.
// RAM_ACCESS_CTRL_INIT_CLEAR_EN adds the INIT state (clear RAM after reset).
package ram_access_ctrl_pkg;

  localparam int DEF_MEM_WIDTH  = 16;
  localparam int DEF_MEM_LENGTH = 8;
  localparam int DEF_ADD_LENGTH = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_CAPT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_WRITE = 3'd4
`ifdef RAM_ACCESS_CTRL_INIT_CLEAR_EN
    ,
    ST_INIT  = 3'd5
`endif
  } state_t;

endpackage

// File: rtl/ram_access_ctrl.sv
// Single-outstanding request controller in front of a dual-read / single-write RAM.
// Reads: READ (RAM strobe) -> CAPT (register RAM data) -> RESP (hold until accepted).
// Writes: WRITE (RAM strobe), wr_done pulses in the following cycle.
// RAM_ACCESS_CTRL_INIT_CLEAR_EN: reset enters INIT, which writes zero to every
// RAM address once before the first request is accepted.
//
// state | meaning
// IDLE  | ready for a request, RAM idle
// READ  | RAM read strobe with latched selects
// CAPT  | RAM data valid, captured at end of cycle
// RESP  | response held until rsp_ready
// WRITE | RAM write strobe with latched address/data
// INIT  | (macro only) clearing RAM, one address per cycle
module ram_access_ctrl
  import ram_access_ctrl_pkg::*;
#(
  parameter int mem_width  = DEF_MEM_WIDTH,
  parameter int mem_length = DEF_MEM_LENGTH,
  parameter int add_length = DEF_ADD_LENGTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [add_length-1:0] req_sel_1,
  input  logic [add_length-1:0] req_sel_2,
  input  logic [add_length-1:0] req_wsel,
  input  logic [mem_width-1:0]  req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [mem_width-1:0]  rsp_data_1,
  output logic [mem_width-1:0]  rsp_data_2,
  output logic                  wr_done,
  output logic                  ram_ce,
  output logic                  ram_rr,
  output logic [add_length-1:0] ram_out_sel_1,
  output logic [add_length-1:0] ram_out_sel_2,
  output logic [add_length-1:0] ram_in_sel,
  output logic [mem_width-1:0]  ram_in_data,
  input  logic [mem_width-1:0]  ram_out_data_1,
  input  logic [mem_width-1:0]  ram_out_data_2
);

`ifdef RAM_ACCESS_CTRL_INIT_CLEAR_EN
  localparam state_t RST_STATE = ST_INIT;
`else
  localparam state_t RST_STATE = ST_IDLE;
`endif

  state_t                state, state_nxt;
  logic [add_length-1:0] sel_1_q, sel_2_q, wsel_q;
  logic [mem_width-1:0]  wdata_q;
  logic                  accept;

  assign accept        = req_valid & req_ready;
  assign ram_out_sel_1 = sel_1_q;
  assign ram_out_sel_2 = sel_2_q;

`ifdef RAM_ACCESS_CTRL_INIT_CLEAR_EN
  logic [add_length-1:0] init_cnt;
  logic                  init_last;

  assign init_last = (init_cnt == add_length'(mem_length - 1));

  // Clear-address counter, advances once per INIT cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) init_cnt <= '0;
    else if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
  end
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RST_STATE;
    else     state <= state_nxt;
  end

  // Latch the whole request on acceptance; RAM selects replay these and hold between accesses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_1_q <= '0;
      sel_2_q <= '0;
      wsel_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      sel_1_q <= req_sel_1;
      sel_2_q <= req_sel_2;
      wsel_q  <= req_wsel;
      wdata_q <= req_wdata;
    end
  end

  // Capture RAM data only at the end of CAPT so a floating bus never reaches the response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_data_1 <= '0;
      rsp_data_2 <= '0;
    end else if (state == ST_CAPT) begin
      rsp_data_1 <= ram_out_data_1;
      rsp_data_2 <= ram_out_data_2;
    end
  end

  // Write-complete pulse in the cycle after the RAM write strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_done <= 1'b0;
    else     wr_done <= (state == ST_WRITE);
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = req_write ? ST_WRITE : ST_READ;
      ST_READ:  state_nxt = ST_CAPT;
      ST_CAPT:  state_nxt = ST_RESP;
      ST_RESP:  if (rsp_ready) state_nxt = ST_IDLE;
      ST_WRITE: state_nxt = ST_IDLE;
`ifdef RAM_ACCESS_CTRL_INIT_CLEAR_EN
      ST_INIT:  if (init_last) state_nxt = ST_IDLE;
`endif
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the current state
  always_comb begin
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    ram_ce      = 1'b0;
    ram_rr      = 1'b0;
    ram_in_sel  = wsel_q;
    ram_in_data = wdata_q;
    case (state)
      ST_IDLE:  req_ready = 1'b1;
      ST_READ:  ram_ce    = 1'b1;
      ST_RESP:  rsp_valid = 1'b1;
      ST_WRITE: begin
        ram_ce = 1'b1;
        ram_rr = 1'b1;
      end
`ifdef RAM_ACCESS_CTRL_INIT_CLEAR_EN
      // Strobe is suppressed while reset is held so the RAM sees no access during reset
      ST_INIT: begin
        ram_ce      = ~rst;
        ram_rr      = ~rst;
        ram_in_sel  = init_cnt;
        ram_in_data = '0;
      end
`endif
      default: ;
    endcase
  end

endmodule
